dec_gray2bin_pipe: RTL



---
 rtl/dec_gray2bin_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dec_gray2bin_pipe.sv
// -----------------------------------------------------------------------------
// dec_gray2bin_pipe
// Pipelined Gray-to-binary decoder. Accepts Gray-coded words over a valid/ready
// stream and presents the binary value STAGES cycles later, one word per cycle.
//
// Parameters:
//   WIDTH   data width in bits (>= 2)
//   STAGES  pipeline register stages (1..WIDTH); each stage resolves
//           K = ceil(WIDTH/STAGES) bits MSB-first, the last stage the remainder
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_gray valid
//   in_ready   decoder can accept in_gray this cycle
//   in_gray    Gray-coded input word
//   out_valid  out_bin valid
//   out_ready  downstream accepts out_bin this cycle
//   out_bin    decoded binary word
//   out_err    code-step error flag qualified by out_valid
//
// Optional feature macro: GRAY_CHECK_EN
//   Defined: each accepted word is compared with the previously accepted code;
//   a Hamming distance above 1 marks that word, and the mark travels with it to
//   out_err. The first word after reset is never marked.
//   Undefined: no compare logic, out_err is tied to 0.
//
// Handshake: a word moves across a boundary only when valid and ready are both
// high in the same cycle. Stage k is ready when it is empty or the stage after
// it is ready (the stage after the last is out_ready); in_ready is stage 0's
// ready. A ready stage loads its upstream valid, so a full pipe with out_ready
// high accepts and emits in the same cycle.
// -----------------------------------------------------------------------------
module dec_gray2bin_pipe #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_err
);

    localparam int K = (WIDTH + STAGES - 1) / STAGES;

    // Highest bit index resolved by stage k (may be negative for stages left
    // with no bits when K*STAGES overshoots WIDTH).
    function automatic int slice_hi(input int k);
        return WIDTH - 1 - k * K;
    endfunction

    // Lowest bit index resolved by stage k; the last stage sweeps to bit 0.
    function automatic int slice_lo(input int k);
        int lo;
        lo = WIDTH - (k + 1) * K;
        if (k == STAGES - 1 || lo < 0) begin
            lo = 0;
        end
        return lo;
    endfunction

    // Bits above hi are already binary; bits in [lo, hi] are converted using
    // the binary bit just above them; bits below lo stay Gray for later stages.
    function automatic logic [WIDTH-1:0] resolve_slice(
        input logic [WIDTH-1:0] w,
        input int               hi,
        input int               lo
    );
        logic [WIDTH-1:0] r;
        r = w;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = r[i+1] ^ r[i];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q  [STAGES];
    logic [WIDTH-1:0] data_d  [STAGES];
    logic [WIDTH-1:0] up_data [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] up_valid;
    logic [STAGES:0]   rdy;

    // Ready chain, computed from the output end back toward the input.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] | rdy[k+1];
        end
    end

    // Upstream view of each stage and its partially decoded next value.
    always_comb begin
        up_valid = '0;
        for (int k = 0; k < STAGES; k++) begin
            up_data[k] = '0;
        end
        up_valid[0] = in_valid;
        up_data[0]  = in_gray;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = valid_q[k-1];
            up_data[k]  = data_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = resolve_slice(up_data[k], slice_hi(k), slice_lo(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= up_valid[k];
                    // Data only moves with a real word so a held bubble keeps
                    // the registers quiet.
                    if (up_valid[k]) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_bin   = data_q[STAGES-1];

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0]  prev_q;
    logic              seen_q;
    logic [WIDTH-1:0]  diff;
    logic              err_new;
    logic [STAGES-1:0] err_q;
    logic [STAGES-1:0] up_err;
    logic              accept;

    assign accept = in_valid & rdy[0];

    // More than one differing bit <=> clearing the lowest set bit leaves
    // something behind.
    always_comb begin
        diff    = in_gray ^ prev_q;
        err_new = seen_q && ((diff & (diff - WIDTH'(1))) != '0);
    end

    always_comb begin
        up_err    = '0;
        up_err[0] = err_new;
        for (int k = 1; k < STAGES; k++) begin
            up_err[k] = err_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            seen_q <= 1'b0;
            err_q  <= '0;
        end else begin
            if (accept) begin
                prev_q <= in_gray;
                seen_q <= 1'b1;
            end
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k] && up_valid[k]) begin
                    err_q[k] <= up_err[k];
                end
            end
        end
    end

    assign out_err = err_q[STAGES-1];
`else
    assign out_err = 1'b0;
`endif

endmodule
